// File: rtl/t07_fpu_writeback_pkg.sv
// Shared types for the FPU register-file write-back slice.
//  t07_wb_entry_t : one pending register write (destination + value)
//  NUM_FREGS      : number of architectural f-registers
package t07_fpu_pkg;

  localparam int NUM_FREGS = 32;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } t07_wb_entry_t;

endpackage

// File: rtl/t07_fpu_writeback_if.sv
// Bundle of all write-back handshake and register-file signals.
//  slave  : the write-back block (consumes FPU/load/issue, drives the register-file write port)
//  master : the surrounding pipeline (FPU, load unit, decode, register file)
interface t07_fpu_writeback_if;

  logic        freeze_i;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic        fpu_valid_i;
  logic [4:0]  fpu_rd_i;
  logic [31:0] fpu_data_i;
  logic        fpu_ready_o;
  logic        ld_valid_i;
  logic [4:0]  ld_rd_i;
  logic [31:0] ld_data_i;
  logic        ld_ready_o;
  logic [4:0]  rd_o;
  logic [31:0] data_o;
  logic        FPUregWrite_o;
  logic        regEnable_o;
  logic [31:0] busy_o;

  modport slave (
    input  freeze_i, issue_i, issue_rd_i,
    input  fpu_valid_i, fpu_rd_i, fpu_data_i,
    input  ld_valid_i, ld_rd_i, ld_data_i,
    output fpu_ready_o, ld_ready_o,
    output rd_o, data_o, FPUregWrite_o, regEnable_o, busy_o
  );

  modport master (
    output freeze_i, issue_i, issue_rd_i,
    output fpu_valid_i, fpu_rd_i, fpu_data_i,
    output ld_valid_i, ld_rd_i, ld_data_i,
    input  fpu_ready_o, ld_ready_o,
    input  rd_o, data_o, FPUregWrite_o, regEnable_o, busy_o
  );

endinterface

// File: rtl/t07_fpu_wb_fifo.sv
// Small FIFO buffering FPU results ahead of the commit stage.
//  clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//  push      : write in_entry this cycle (ignored when full)
//  pop       : drop the head this cycle (ignored when empty)
//  in_entry  : entry to push
//  head      : oldest entry (valid when !empty)
//  full/empty: occupancy flags
module t07_fpu_wb_fifo
  import t07_fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  t07_wb_entry_t in_entry,
  output t07_wb_entry_t head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  t07_wb_entry_t mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage write; data needs no reset because occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= in_entry;
    end
  end

  // Pointer update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/t07_fpu_writeback.sv
// FPU register-file write-side driver.
//  clk, rst : clock, synchronous active-high reset
//  wb       : slave side of t07_fpu_writeback_if
//             inputs : freeze, issue + issue_rd, FPU result channel, load channel
//             outputs: fpu_ready (FIFO not full), ld_ready (not frozen),
//                      rd/data/FPUregWrite/regEnable write port, busy bitmap
// Loads take priority over buffered FPU results; one write is committed per
// unfrozen cycle. The busy bitmap tracks issued destinations until their write.
module t07_fpu_writeback
  import t07_fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  t07_fpu_writeback_if.slave   wb
);

  t07_wb_entry_t          fifo_in;
  t07_wb_entry_t          fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;

  t07_wb_entry_t          out_entry;
  logic                   out_valid;
  logic                   out_write;

  t07_wb_entry_t          sel_entry;
  logic                   sel_valid;

  logic [NUM_FREGS-1:0]   busy;
  logic [NUM_FREGS-1:0]   busy_next;

  assign fifo_in = '{rd: wb.fpu_rd_i, data: wb.fpu_data_i};

  t07_fpu_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wb.fpu_valid_i),
    .pop      (fifo_pop),
    .in_entry (fifo_in),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Commit select: hold while frozen, else load first, then FIFO head, else idle.
  always_comb begin
    sel_entry = out_entry;
    sel_valid = out_valid;
    fifo_pop  = 1'b0;
    if (wb.freeze_i) begin
      sel_entry = out_entry;
      sel_valid = out_valid;
    end else if (wb.ld_valid_i) begin
      sel_entry = '{rd: wb.ld_rd_i, data: wb.ld_data_i};
      sel_valid = 1'b1;
    end else if (!fifo_empty) begin
      sel_entry = fifo_head;
      sel_valid = 1'b1;
      fifo_pop  = 1'b1;
    end else begin
      sel_valid = 1'b0;
    end
  end

  // Output stage register; the write strobe is precomputed so f0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_entry <= '0;
      out_valid <= 1'b0;
      out_write <= 1'b0;
    end else begin
      out_entry <= sel_entry;
      out_valid <= sel_valid;
      out_write <= sel_valid && (sel_entry.rd != 5'd0);
    end
  end

  // Scoreboard next state: clear on a real write, then set on issue so a same-index set wins.
  always_comb begin
    busy_next = busy;
    if (out_write && !wb.freeze_i) begin
      busy_next[out_entry.rd] = 1'b0;
    end else begin
      busy_next = busy;
    end
    if (wb.issue_i && (wb.issue_rd_i != 5'd0)) begin
      busy_next[wb.issue_rd_i] = 1'b1;
    end else begin
      busy_next[0] = 1'b0;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign wb.fpu_ready_o   = !fifo_full;
  assign wb.ld_ready_o    = !wb.freeze_i;
  assign wb.rd_o          = out_entry.rd;
  assign wb.data_o        = out_entry.data;
  assign wb.regEnable_o   = out_valid;
  assign wb.FPUregWrite_o = out_write;
  assign wb.busy_o        = busy;

endmodule

// File: tb/tb_t07_fpu_writeback.sv
// Self-checking bench for t07_fpu_writeback: directed scenarios followed by
// randomized traffic, all checked against a queue-based behavioural model.
module tb_t07_fpu_writeback;
  import t07_fpu_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  t07_fpu_writeback_if wbif ();

  t07_fpu_writeback #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wbif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: pending FPU results, the current register-file write, pending regs.
  t07_wb_entry_t m_q [$];
  logic          m_valid = 1'b0;
  t07_wb_entry_t m_out   = '0;
  logic [31:0]   m_busy  = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply the behavioural rules for one clock edge, using the inputs held across it.
  task automatic model_edge();
    logic accept;
    if (rst) begin
      m_q.delete();
      m_valid = 1'b0;
      m_out   = '0;
      m_busy  = 32'd0;
    end else begin
      accept = wbif.fpu_valid_i && (m_q.size() < DEPTH);
      if (m_valid && (m_out.rd != 5'd0) && !wbif.freeze_i) m_busy[m_out.rd] = 1'b0;
      if (wbif.issue_i && (wbif.issue_rd_i != 5'd0)) m_busy[wbif.issue_rd_i] = 1'b1;
      if (!wbif.freeze_i) begin
        if (wbif.ld_valid_i) begin
          m_out   = '{rd: wbif.ld_rd_i, data: wbif.ld_data_i};
          m_valid = 1'b1;
        end else if (m_q.size() > 0) begin
          m_out   = m_q.pop_front();
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (accept) m_q.push_back('{rd: wbif.fpu_rd_i, data: wbif.fpu_data_i});
    end
  endtask

  task automatic compare_all();
    check_val("regEnable", 32'(wbif.regEnable_o), 32'(m_valid));
    check_val("FPUregWrite", 32'(wbif.FPUregWrite_o), 32'(m_valid && (m_out.rd != 5'd0)));
    if (m_valid) begin
      check_val("rd", 32'(wbif.rd_o), 32'(m_out.rd));
      check_val("data", wbif.data_o, m_out.data);
    end
    check_val("busy", wbif.busy_o, m_busy);
    check_val("fpu_ready", 32'(wbif.fpu_ready_o), 32'(m_q.size() < DEPTH));
    check_val("ld_ready", 32'(wbif.ld_ready_o), 32'(!wbif.freeze_i));
  endtask

  task automatic step(input logic fr, input logic is, input logic [4:0] ird,
                      input logic fv, input logic [4:0] frd, input logic [31:0] fd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldd);
    @(negedge clk);
    wbif.freeze_i    = fr;
    wbif.issue_i     = is;
    wbif.issue_rd_i  = ird;
    wbif.fpu_valid_i = fv;
    wbif.fpu_rd_i    = frd;
    wbif.fpu_data_i  = fd;
    wbif.ld_valid_i  = lv;
    wbif.ld_rd_i     = lrd;
    wbif.ld_data_i   = ldd;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input logic fr);
    step(fr, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic push_fpu(input logic fr, input logic [4:0] frd, input logic [31:0] fd);
    step(fr, 1'b0, 5'd0, 1'b1, frd, fd, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic issue(input logic [4:0] ird);
    step(1'b0, 1'b1, ird, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    // Reset held two cycles with an FPU result offered: nothing may be pushed.
    rst = 1'b1;
    push_fpu(1'b0, 5'd1, 32'h1111_1111);
    push_fpu(1'b0, 5'd1, 32'h1111_1111);
    check_val("rst_rd", 32'(wbif.rd_o), 32'd0);
    check_val("rst_data", wbif.data_o, 32'd0);
    check_val("rst_regEnable", 32'(wbif.regEnable_o), 32'd0);
    check_val("rst_busy", wbif.busy_o, 32'd0);
    check_val("rst_fpu_ready", 32'(wbif.fpu_ready_o), 32'd1);
    rst = 1'b0;
    idle(1'b0);
    idle(1'b0);
    check_val("rst_nothing_pushed", 32'(wbif.regEnable_o), 32'd0);

    // Basic FPU write: two-cycle latency, scoreboard cleared by the write.
    issue(5'd3);
    check_val("t2_busy_set", 32'(wbif.busy_o[3]), 32'd1);
    push_fpu(1'b0, 5'd3, 32'h3F80_0000);
    check_val("t2_not_yet", 32'(wbif.regEnable_o), 32'd0);
    idle(1'b0);
    check_val("t2_rd", 32'(wbif.rd_o), 32'd3);
    check_val("t2_data", wbif.data_o, 32'h3F80_0000);
    check_val("t2_we", 32'(wbif.FPUregWrite_o), 32'd1);
    check_val("t2_busy_held", 32'(wbif.busy_o[3]), 32'd1);
    idle(1'b0);
    check_val("t2_busy_clr", 32'(wbif.busy_o[3]), 32'd0);

    // Load beats the FIFO head in the same cycle.
    push_fpu(1'b0, 5'd6, 32'h4040_0000);
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h4000_0000);
    check_val("t3_load_first", 32'(wbif.rd_o), 32'd5);
    check_val("t3_load_data", wbif.data_o, 32'h4000_0000);
    idle(1'b0);
    check_val("t3_fifo_next", 32'(wbif.rd_o), 32'd6);
    idle(1'b0);

    // Fill while frozen, then drain in order; the fifth result waits for space.
    for (int i = 0; i < 4; i++) push_fpu(1'b1, 5'(10 + i), 32'(32'hA000_0000 + i));
    check_val("t4_full", 32'(wbif.fpu_ready_o), 32'd0);
    push_fpu(1'b1, 5'd14, 32'hA000_0004);
    push_fpu(1'b0, 5'd14, 32'hA000_0004);
    check_val("t4_c0", 32'(wbif.rd_o), 32'd10);
    push_fpu(1'b0, 5'd14, 32'hA000_0004);
    check_val("t4_c1", 32'(wbif.rd_o), 32'd11);
    idle(1'b0);
    check_val("t4_c2", 32'(wbif.rd_o), 32'd12);
    idle(1'b0);
    check_val("t4_c3", 32'(wbif.rd_o), 32'd13);
    idle(1'b0);
    check_val("t4_c4", 32'(wbif.rd_o), 32'd14);
    check_val("t4_c4_data", wbif.data_o, 32'hA000_0004);
    idle(1'b0);
    check_val("t4_drained", 32'(wbif.regEnable_o), 32'd0);

    // Freeze while a write is on the port: it and its busy bit hold.
    issue(5'd7);
    push_fpu(1'b0, 5'd7, 32'h7777_7777);
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check_val("t5_hold_rd", 32'(wbif.rd_o), 32'd7);
      check_val("t5_hold_busy", 32'(wbif.busy_o[7]), 32'd1);
    end
    idle(1'b0);
    check_val("t5_busy_clr", 32'(wbif.busy_o[7]), 32'd0);

    // f0 never becomes busy nor gets written; same-cycle set and clear keeps the bit.
    issue(5'd0);
    check_val("t6_busy0", 32'(wbif.busy_o[0]), 32'd0);
    push_fpu(1'b0, 5'd0, 32'hDEAD_BEEF);
    idle(1'b0);
    check_val("t6_rd0_en", 32'(wbif.regEnable_o), 32'd1);
    check_val("t6_rd0_we", 32'(wbif.FPUregWrite_o), 32'd0);
    issue(5'd9);
    push_fpu(1'b0, 5'd9, 32'h9999_9999);
    idle(1'b0);
    check_val("t6_rd9_we", 32'(wbif.FPUregWrite_o), 32'd1);
    issue(5'd9);
    check_val("t6_set_wins", 32'(wbif.busy_o[9]), 32'd1);

    // Randomized traffic, including occasional mid-run resets.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(99) == 0);
      step($urandom_range(3) == 0,
           $urandom_range(2) == 0, 5'($urandom_range(31)),
           $urandom_range(1) == 0, 5'($urandom_range(31)), $urandom,
           $urandom_range(4) == 0, 5'($urandom_range(31)), $urandom);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
